// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and helpers for the unified memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        ARB_PORT_CORE = 1'b0,
        ARB_PORT_DBG  = 1'b1
    } arb_port_t;

    // Timeout counter width; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker2.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_rr_picker2
// Description : Combinational two-way picker; one-hot grant, round-robin or
//               fixed core priority on contention.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr_picker2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_port_t  last_grant,
    input  logic       prio_core,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio_core || (last_grant == ARB_PORT_DBG)) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between core and debug loader; one
//               outstanding access, per-access timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 255,
    parameter int CPU_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int               STRB_W     = DATA_W / 8;
    localparam int               CNT_W      = cnt_width(TIMEOUT);
    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic             PRIO_CORE  = (CPU_PRIO != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    arb_state_t          r_state;
    arb_port_t           r_owner;
    arb_port_t           r_last_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_c_rvalid, r_d_rvalid;
    logic                r_c_err, r_d_err;
    logic [DATA_W-1:0]   r_c_rdata, r_d_rdata;

    logic [1:0]          w_grant;
    logic                w_idle, w_busy, w_timeout, w_done, w_sel_dbg;

    mem_arbiter_rr_picker2 u_picker (
        .req        ({d_req, c_req}),
        .last_grant (r_last_grant),
        .prio_core  (PRIO_CORE),
        .grant      (w_grant)
    );

    assign w_idle    = (r_state == ARB_IDLE);
    assign w_busy    = (r_state == ARB_BUSY);
    assign w_sel_dbg = w_grant[1];
    // A same-cycle mem_ready beats the abort.
    assign w_timeout = TIMEOUT_EN && w_busy && !mem_ready && (r_cnt == CNT_LAST);
    assign w_done    = w_busy && (mem_ready || w_timeout);

    // Gate with reset so grants stay low while reset is asserted.
    assign c_gnt     = reset && w_idle && w_grant[0];
    assign d_gnt     = reset && w_idle && w_grant[1];

    assign mem_req   = w_busy;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign busy      = w_busy;
    assign c_rvalid  = r_c_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign c_err     = r_c_err;
    assign d_err     = r_d_err;
    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_PORT_CORE;
            r_last_grant <= ARB_PORT_DBG;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_cnt        <= '0;
            r_c_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_c_err      <= 1'b0;
            r_d_err      <= 1'b0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_err    <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant != 2'b00) begin
                        r_state      <= ARB_BUSY;
                        r_owner      <= w_sel_dbg ? ARB_PORT_DBG : ARB_PORT_CORE;
                        r_last_grant <= w_sel_dbg ? ARB_PORT_DBG : ARB_PORT_CORE;
                        r_we         <= w_sel_dbg ? d_we    : c_we;
                        r_addr       <= w_sel_dbg ? d_addr  : c_addr;
                        r_wdata      <= w_sel_dbg ? d_wdata : c_wdata;
                        r_wstrb      <= w_sel_dbg ? (d_we ? d_wstrb : '0)
                                                  : (c_we ? c_wstrb : '0);
                    end
                end
                ARB_BUSY: begin
                    if (w_done) begin
                        r_state <= ARB_IDLE;
                        r_cnt   <= '0;
                        if (r_owner == ARB_PORT_CORE) begin
                            r_c_rvalid <= 1'b1;
                            r_c_err    <= w_timeout;
                            if (w_timeout)
                                r_c_rdata <= '0;
                            else if (!r_we)
                                r_c_rdata <= mem_rdata;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            r_d_err    <= w_timeout;
                            if (w_timeout)
                                r_d_rdata <= '0;
                            else if (!r_we)
                                r_d_rdata <= mem_rdata;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
